// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation tank plant model:
// sensor fault codes, tank states, level bundle and default constants.
package irrigation_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE        = 2'b00,
        FAULT_LOW_STUCK0  = 2'b01,
        FAULT_HIGH_STUCK1 = 2'b10,
        FAULT_MID_STUCK0  = 2'b11
    } fault_sel_e;

    typedef enum logic [1:0] {
        TANK_RUN   = 2'b00,
        TANK_FULL  = 2'b01,
        TANK_EMPTY = 2'b10
    } tank_state_e;

    typedef struct packed {
        logic low;
        logic mid;
        logic high;
    } level_t;

    localparam int unsigned DEF_VOLUME_WIDTH   = 8;
    localparam int unsigned DEF_CAPACITY       = 200;
    localparam int unsigned DEF_LOW_THRESH     = 40;
    localparam int unsigned DEF_MID_THRESH     = 100;
    localparam int unsigned DEF_HIGH_THRESH    = 160;
    localparam int unsigned DEF_FILL_RATE      = 4;
    localparam int unsigned DEF_SPRINKLER_RATE = 3;
    localparam int unsigned DEF_DRIPPER_RATE   = 1;
    localparam int unsigned DEF_TICK_DIV       = 50000;
    localparam int unsigned DEF_INIT_VOLUME    = 0;

    function automatic level_t apply_fault(input level_t raw, input logic [1:0] sel);
        level_t lvl;
        lvl = raw;
        case (fault_sel_e'(sel))
            FAULT_LOW_STUCK0:  lvl.low  = 1'b0;
            FAULT_HIGH_STUCK1: lvl.high = 1'b1;
            FAULT_MID_STUCK0:  lvl.mid  = 1'b0;
            default:           lvl      = raw;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/tank_tick_generator.sv
// Update-tick prescaler: counts enabled cycles and pulses once every TICK_DIV of them.
module tank_tick_generator
    import irrigation_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == LAST);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_enable & w_last;

endmodule

// File: rtl/water_tank_model.sv
// Behavioural tank plant: integrates actuator flows once per tick, drives level
// sensors (with optional fault injection) and reports FULL/EMPTY conditions.
module water_tank_model
    import irrigation_pkg::*;
#(
    parameter int unsigned VOLUME_WIDTH   = DEF_VOLUME_WIDTH,
    parameter int unsigned CAPACITY       = DEF_CAPACITY,
    parameter int unsigned LOW_THRESH     = DEF_LOW_THRESH,
    parameter int unsigned MID_THRESH     = DEF_MID_THRESH,
    parameter int unsigned HIGH_THRESH    = DEF_HIGH_THRESH,
    parameter int unsigned FILL_RATE      = DEF_FILL_RATE,
    parameter int unsigned SPRINKLER_RATE = DEF_SPRINKLER_RATE,
    parameter int unsigned DRIPPER_RATE   = DEF_DRIPPER_RATE,
    parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
    parameter int unsigned INIT_VOLUME    = DEF_INIT_VOLUME
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    water_supply_valvule,
    input  logic                    splinker_bomb,
    input  logic                    dripper_valvule,
    input  logic                    load_volume,
    input  logic [VOLUME_WIDTH-1:0] load_value,
    input  logic [1:0]              fault_sel,
    output logic                    low_water_level,
    output logic                    mid_water_level,
    output logic                    high_water_level,
    output logic [VOLUME_WIDTH-1:0] volume,
    output logic                    tick,
    output logic                    overflow,
    output logic                    dry
);

    localparam int unsigned NET_W = VOLUME_WIDTH + 2;

    localparam logic [VOLUME_WIDTH-1:0] CAP_V  = VOLUME_WIDTH'(CAPACITY);
    localparam logic [VOLUME_WIDTH-1:0] INIT_V = VOLUME_WIDTH'(INIT_VOLUME);
    localparam logic [VOLUME_WIDTH-1:0] LOW_V  = VOLUME_WIDTH'(LOW_THRESH);
    localparam logic [VOLUME_WIDTH-1:0] MID_V  = VOLUME_WIDTH'(MID_THRESH);
    localparam logic [VOLUME_WIDTH-1:0] HIGH_V = VOLUME_WIDTH'(HIGH_THRESH);

    localparam logic signed [NET_W-1:0] CAP_S  = NET_W'(CAPACITY);
    localparam logic signed [NET_W-1:0] FILL_S = NET_W'(FILL_RATE);
    localparam logic signed [NET_W-1:0] SPR_S  = NET_W'(SPRINKLER_RATE);
    localparam logic signed [NET_W-1:0] DRIP_S = NET_W'(DRIPPER_RATE);

    function automatic level_t level_of(input logic [VOLUME_WIDTH-1:0] v);
        level_t lvl;
        lvl.low  = (v >= LOW_V);
        lvl.mid  = (v >= MID_V);
        lvl.high = (v >= HIGH_V);
        return lvl;
    endfunction

    localparam level_t INIT_LEVEL = level_of(INIT_V);
    localparam tank_state_e INIT_STATE =
        (INIT_VOLUME == CAPACITY) ? TANK_FULL :
        ((INIT_VOLUME == 0) ? TANK_EMPTY : TANK_RUN);

    logic                     w_tick;
    logic signed [NET_W-1:0]  w_net;
    logic signed [NET_W-1:0]  w_sum;
    logic [VOLUME_WIDTH-1:0]  w_tick_vol;
    logic [VOLUME_WIDTH-1:0]  w_load_vol;
    level_t                   w_level_out;
    tank_state_e              w_state_next;

    logic [VOLUME_WIDTH-1:0]  r_volume;
    logic                     r_act_valve;
    logic                     r_act_drain;
    logic                     r_eval;
    level_t                   r_level;
    tank_state_e              r_state;
    logic                     r_overflow;
    logic                     r_dry;

    tank_tick_generator #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_enable  (enable),
        .o_tick    (w_tick)
    );

    // Net flow is evaluated two bits wider than the volume so both the
    // underflow below zero and the overshoot past CAPACITY are visible.
    always_comb begin
        w_net = '0;
        if (water_supply_valvule) w_net = w_net + FILL_S;
        if (splinker_bomb)        w_net = w_net - SPR_S;
        if (dripper_valvule)      w_net = w_net - DRIP_S;
        w_sum = $signed({2'b00, r_volume}) + w_net;
        if (w_sum[NET_W-1]) begin
            w_tick_vol = '0;
        end else if (w_sum > CAP_S) begin
            w_tick_vol = CAP_V;
        end else begin
            w_tick_vol = w_sum[VOLUME_WIDTH-1:0];
        end
    end

    assign w_load_vol = (load_value > CAP_V) ? CAP_V : load_value;

    // Actuators are captured on the tick so the state evaluation on the
    // following cycle sees the flows that produced the new volume.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_volume    <= INIT_V;
            r_act_valve <= 1'b0;
            r_act_drain <= 1'b0;
            r_eval      <= 1'b0;
        end else begin
            if (load_volume) begin
                r_volume <= w_load_vol;
            end else if (w_tick) begin
                r_volume <= w_tick_vol;
            end
            if (w_tick) begin
                r_act_valve <= water_supply_valvule;
                r_act_drain <= splinker_bomb | dripper_valvule;
            end
            r_eval <= load_volume | w_tick;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= INIT_LEVEL;
        end else begin
            r_level <= level_of(r_volume);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT_STATE;
            r_overflow <= (INIT_STATE == TANK_FULL);
            r_dry      <= (INIT_STATE == TANK_EMPTY);
        end else begin
            r_state    <= w_state_next;
            r_overflow <= (w_state_next == TANK_FULL);
            r_dry      <= (w_state_next == TANK_EMPTY);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_eval) begin
            case (r_state)
                TANK_RUN: begin
                    if (r_volume == CAP_V && r_act_valve) begin
                        w_state_next = TANK_FULL;
                    end else if (r_volume == '0 && r_act_drain) begin
                        w_state_next = TANK_EMPTY;
                    end
                end
                TANK_FULL: begin
                    if (!r_act_valve || r_volume < CAP_V) w_state_next = TANK_RUN;
                end
                TANK_EMPTY: begin
                    if (!r_act_drain || r_volume != '0) w_state_next = TANK_RUN;
                end
                default: w_state_next = TANK_RUN;
            endcase
        end
    end

    assign w_level_out      = apply_fault(r_level, fault_sel);
    assign low_water_level  = w_level_out.low;
    assign mid_water_level  = w_level_out.mid;
    assign high_water_level = w_level_out.high;
    assign volume           = r_volume;
    assign tick             = w_tick;
    assign overflow         = r_overflow;
    assign dry              = r_dry;

endmodule

// File: tb/tb_water_tank_model.sv
// Scoreboard bench for water_tank_model: a plain arithmetic tank model predicts
// each tick's volume, levels and FULL/EMPTY flags; a monitor checks them.
module tb_water_tank_model;

    localparam int TD    = 4;
    localparam int CAP   = 200;
    localparam int LOWT  = 40;
    localparam int MIDT  = 100;
    localparam int HIGHT = 160;
    localparam int FR    = 4;
    localparam int SR    = 3;
    localparam int DR    = 1;
    localparam int S_RUN   = 0;
    localparam int S_FULL  = 1;
    localparam int S_EMPTY = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       water_supply_valvule = 1'b0;
    logic       splinker_bomb = 1'b0;
    logic       dripper_valvule = 1'b0;
    logic       load_volume = 1'b0;
    logic [7:0] load_value = '0;
    logic [1:0] fault_sel = '0;
    logic       low_water_level, mid_water_level, high_water_level;
    logic [7:0] volume;
    logic       tick, overflow, dry;

    water_tank_model #(.TICK_DIV(TD)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .enable               (enable),
        .water_supply_valvule (water_supply_valvule),
        .splinker_bomb        (splinker_bomb),
        .dripper_valvule      (dripper_valvule),
        .load_volume          (load_volume),
        .load_value           (load_value),
        .fault_sel            (fault_sel),
        .low_water_level      (low_water_level),
        .mid_water_level      (mid_water_level),
        .high_water_level     (high_water_level),
        .volume               (volume),
        .tick                 (tick),
        .overflow             (overflow),
        .dry                  (dry)
    );

    always #5 clock = ~clock;

    typedef struct { int vol; int st; } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    // Reference tank: volume, state, enabled-cycle phase, flows seen at the last tick.
    int m_cnt, m_vol, m_state, m_tick_vol;
    bit m_v, m_s, m_d, m_eval, m_prev_tick;
    bit exp_tick = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_levels(input int vol, input logic [1:0] fs);
        bit lo, mi, hi;
        lo = (vol >= LOWT);
        mi = (vol >= MIDT);
        hi = (vol >= HIGHT);
        if (fs == 2'b01) lo = 1'b0;
        if (fs == 2'b10) hi = 1'b1;
        if (fs == 2'b11) mi = 1'b0;
        return {29'd0, lo, mi, hi};
    endfunction

    function automatic int next_state(input int st, input int vol, input bit v, input bit s, input bit d);
        if (st == S_RUN) begin
            if (vol == CAP && v) return S_FULL;
            if (vol == 0 && (s || d)) return S_EMPTY;
            return S_RUN;
        end
        if (st == S_FULL) return (!v || vol < CAP) ? S_RUN : S_FULL;
        return (!(s || d) || vol > 0) ? S_RUN : S_EMPTY;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_vol = 0; m_state = S_EMPTY; m_tick_vol = 0;
        m_v = 0; m_s = 0; m_d = 0; m_eval = 0; m_prev_tick = 0;
        exp_tick = 0;
    endtask

    task automatic model_edge();
        bit t;
        int n;
        t = exp_tick;
        if (m_eval) m_state = next_state(m_state, m_vol, m_v, m_s, m_d);
        if (m_prev_tick) q.push_back('{m_tick_vol, m_state});
        m_eval = load_volume || t;
        if (load_volume) begin
            m_vol = (int'(load_value) > CAP) ? CAP : int'(load_value);
        end else if (t) begin
            n = m_vol + (water_supply_valvule ? FR : 0) - (splinker_bomb ? SR : 0)
                - (dripper_valvule ? DR : 0);
            m_vol = (n < 0) ? 0 : ((n > CAP) ? CAP : n);
        end
        if (t) begin
            m_v = water_supply_valvule; m_s = splinker_bomb; m_d = dripper_valvule;
            m_tick_vol = m_vol;
        end
        m_prev_tick = t;
        if (enable) m_cnt = (m_cnt + 1) % TD;
    endtask

    // Called at posedge+1; drives one cycle of inputs and advances the model over the edge.
    task automatic cycle(input bit en, input bit v, input bit s, input bit d,
                         input bit ld, input int lv);
        int lv_v;
        lv_v = lv;
        enable = en; water_supply_valvule = v; splinker_bomb = s; dripper_valvule = d;
        load_volume = ld; load_value = lv_v[7:0];
        exp_tick = en && reset_n && (m_cnt == TD - 1);
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic run_ticks(input int n, input bit v, input bit s, input bit d);
        int got;
        got = 0;
        while (got < n) begin
            cycle(1, v, s, d, 0, 0);
            if (m_prev_tick) got++;
        end
        repeat (2) cycle(1, v, s, d, 0, 0);
    endtask

    always @(negedge clock) check("tick", tick, exp_tick);

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && tick === 1'b1) begin
                int sv;
                exp_t e;
                @(negedge clock);
                sv = volume;
                @(negedge clock);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: DUT ticked, model expected no tick at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("sb_volume", sv, e.vol);
                    check("sb_levels", {low_water_level, mid_water_level, high_water_level},
                          exp_levels(e.vol, fault_sel));
                    check("sb_overflow", overflow, int'(e.st == S_FULL));
                    check("sb_dry", dry, int'(e.st == S_EMPTY));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mode;
        bit en, v, s, d, ld;
        model_reset();
        @(posedge clock); #1;
        check("rst_volume", volume, 0);
        check("rst_levels", {low_water_level, mid_water_level, high_water_level}, 0);
        check("rst_dry", dry, 1);
        check("rst_overflow", overflow, 0);
        check("rst_tick", tick, 0);
        reset_n = 1'b1;

        run_ticks(10, 1, 0, 0);
        check("fill10_volume", volume, 40);
        check("fill10_low", low_water_level, 1);
        check("fill10_mid", mid_water_level, 0);
        check("fill10_dry", dry, 0);

        run_ticks(45, 1, 0, 0);
        check("sat_volume", volume, 200);
        check("sat_high", high_water_level, 1);
        check("sat_overflow", overflow, 1);

        run_ticks(1, 0, 0, 0);
        check("valve_off_overflow", overflow, 0);
        check("valve_off_volume", volume, 200);

        cycle(1, 0, 0, 0, 1, 45);
        run_ticks(1, 0, 1, 1);
        check("drain1_volume", volume, 41);
        check("drain1_low", low_water_level, 1);
        run_ticks(1, 0, 1, 1);
        check("drain2_volume", volume, 37);
        check("drain2_low", low_water_level, 0);

        while (m_cnt != TD - 1) cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 77);
        check("load_vs_tick", volume, 77);

        cycle(1, 0, 0, 0, 1, 99);
        run_ticks(1, 1, 1, 0);
        check("mid_cross_volume", volume, 100);
        check("mid_cross_mid", mid_water_level, 1);
        cycle(1, 0, 0, 0, 1, 250);
        check("load_clamp", volume, 200);

        cycle(1, 0, 0, 0, 1, 0);
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        fault_sel = 2'b10;
        #1;
        check("fault_high", high_water_level, 1);
        check("fault_low", low_water_level, 0);
        fault_sel = 2'b00;

        while (m_cnt != 2) cycle(1, 1, 0, 0, 0, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midreset_volume", volume, 0);
        check("midreset_tick", tick, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0, 0);
            check("restart_tick", tick, int'(i == 2));
        end

        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) mode = $urandom_range(0, 2);
            if (i % 97 == 0) fault_sel = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            if (mode == 0) begin
                v = ($urandom_range(0, 3) != 0); s = ($urandom_range(0, 3) == 0); d = $urandom_range(0, 1) != 0;
            end else if (mode == 1) begin
                v = ($urandom_range(0, 3) == 0); s = ($urandom_range(0, 3) != 0); d = $urandom_range(0, 1) != 0;
            end else begin
                v = $urandom_range(0, 1) != 0; s = $urandom_range(0, 1) != 0; d = $urandom_range(0, 1) != 0;
            end
            ld = ($urandom_range(0, 40) == 0);
            cycle(en, v, s, d, ld, $urandom_range(0, 255));
        end

        repeat (6) cycle(0, 0, 0, 0, 0, 0);
        check("sb_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
